// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: PC-select encodings and instruction constants.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JMP = 2'b10,
    PCSEL_RSV = 2'b11
  } pc_sel_e;
endpackage

// File: rtl/if_imem.sv
// Word-addressed instruction memory: one write port, one combinational read port.
// Read-before-write: a same-edge write becomes visible to the read port after that edge.
module if_imem
  import mips_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch: PC, next-PC select, instruction memory and IF/ID register (1-cycle latency).
// Redirect beats STALL; STALL holds PC and IF/ID, FLUSH turns IF/ID into a bubble.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic [1:0]         PC_SEL,
  input  logic [31:0]        BR_TARGET,
  input  logic [31:0]        JMP_TARGET,
  input  logic               IMEM_WE,
  input  logic [ADDR_W-1:0]  IMEM_WADDR,
  input  logic [INSTR_W-1:0] IMEM_WDATA,
  output logic [31:0]        PC_OUT,
  output logic [31:0]        NEXT_INS_ADR,
  output logic [INSTR_W-1:0] CUR_INS,
  output logic               IF_VALID,
  output logic               ADR_ERR,
  output logic [CNT_W-1:0]   FETCH_CNT
);

  logic [31:0]        r_pc;
  logic [31:0]        r_next_ins_adr;
  logic [INSTR_W-1:0] r_cur_ins;
  logic               r_if_valid;
  logic               r_adr_err;
  logic [CNT_W-1:0]   r_fetch_cnt;

  logic [INSTR_W-1:0] w_rdata;
  logic [31:0]        w_pc_plus4;
  logic               w_oor;
  logic               w_redirect;
  logic [31:0]        w_target;
  pc_sel_e            w_sel;

  if_imem #(.ADDR_W(ADDR_W)) u_imem (
    .i_clk   (CLK),
    .i_we    (IMEM_WE),
    .i_waddr (IMEM_WADDR),
    .i_wdata (IMEM_WDATA),
    .i_raddr (r_pc[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  assign w_sel      = pc_sel_e'(PC_SEL);
  assign w_pc_plus4 = r_pc + 32'd4;
  // Any PC bit above the memory's byte range means the fetch falls outside the image.
  assign w_oor      = |r_pc[31:ADDR_W+2];

  always_comb begin
    w_redirect = (w_sel == PCSEL_BR) || (w_sel == PCSEL_JMP);
    w_target   = (w_sel == PCSEL_JMP) ? JMP_TARGET : BR_TARGET;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc           <= RESET_PC;
      r_next_ins_adr <= '0;
      r_cur_ins      <= NOP_INSTR;
      r_if_valid     <= 1'b0;
      r_adr_err      <= 1'b0;
      r_fetch_cnt    <= '0;
    end else if (w_redirect) begin
      r_pc           <= {w_target[31:2], 2'b00};
      r_next_ins_adr <= '0;
      r_cur_ins      <= NOP_INSTR;
      r_if_valid     <= 1'b0;
      if (|w_target[1:0]) begin
        r_adr_err <= 1'b1;
      end
    end else if (STALL) begin
      if (FLUSH) begin
        r_next_ins_adr <= '0;
        r_cur_ins      <= NOP_INSTR;
        r_if_valid     <= 1'b0;
      end
    end else begin
      r_pc <= w_pc_plus4;
      if (w_oor) begin
        r_adr_err <= 1'b1;
      end
      if (FLUSH || w_oor) begin
        r_cur_ins      <= NOP_INSTR;
        r_if_valid     <= 1'b0;
        r_next_ins_adr <= FLUSH ? 32'd0 : w_pc_plus4;
      end else begin
        r_cur_ins      <= w_rdata;
        r_next_ins_adr <= w_pc_plus4;
        r_if_valid     <= 1'b1;
        r_fetch_cnt    <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign PC_OUT       = r_pc;
  assign NEXT_INS_ADR = r_next_ins_adr;
  assign CUR_INS      = r_cur_ins;
  assign IF_VALID     = r_if_valid;
  assign ADR_ERR      = r_adr_err;
  assign FETCH_CNT    = r_fetch_cnt;

endmodule
